// File: rtl/freq_count_pkg.sv
// Shared constants for the gated frequency counter.
// Optional feature macro: FREQ_COUNT_SATURATE_EN (saturating edge counter plus overflow flag).
package freq_count_pkg;

    localparam int COUNT_WIDTH_DEFAULT = 28;
    localparam int GATE_WIDTH_DEFAULT  = 32;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Nominal system clock; a quarter of it gives a 0.25 s gate, so software scales code by 4.
    localparam int NOMINAL_CLK_HZ      = 27000000;
    localparam int NOMINAL_GATE_CYCLES = NOMINAL_CLK_HZ / 4;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// one-cycle rising-edge pulse generator. SYNC_STAGES must be at least 2.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;

    // Shift the raw input through the synchronizer chain and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~delayed_q;

endmodule

// File: rtl/freq_count_gate.sv
// Gated frequency counter: counts synchronized rising edges of iclk over a
// window of clk_frequency_div4 system clocks, publishes the count as code and
// raises a sticky interrupt at every window end.
// Optional feature macro: FREQ_COUNT_SATURATE_EN -- edge counter saturates at
// all-ones and an extra overflow output flags windows that saturated.
import freq_count_pkg::*;

module freq_count_gate #(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
    parameter int GATE_WIDTH  = GATE_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iclk,
    input  logic [GATE_WIDTH-1:0]  clk_frequency_div4,
    output logic [COUNT_WIDTH-1:0] code,
`ifdef FREQ_COUNT_SATURATE_EN
    output logic                   overflow,
`endif
    output logic                   interrupt,
    input  logic                   interrupt_clear
);

    logic                   rise;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [GATE_WIDTH-1:0]  gate_last;
    logic                   window_end;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (iclk),
        .rise     (rise)
    );

    // A limit of 0 or 1 both mean a one-cycle window; >= lets a shrinking limit end the window at once.
    assign gate_last  = (clk_frequency_div4 == '0) ? '0 : clk_frequency_div4 - GATE_WIDTH'(1);
    assign window_end = (gate_cnt >= gate_last);

`ifdef FREQ_COUNT_SATURATE_EN
    logic sat_now;
    logic sat_seen;

    // Add this cycle's edge, holding at all-ones instead of wrapping.
    always_comb begin
        count_next = edge_cnt;
        sat_now    = 1'b0;
        if (rise) begin
            if (&edge_cnt) begin
                sat_now = 1'b1;
            end else begin
                count_next = edge_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    // Remember whether any edge was dropped by saturation in the current window and publish it with code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_seen <= 1'b0;
            overflow <= 1'b0;
        end else if (window_end) begin
            sat_seen <= 1'b0;
            overflow <= sat_seen | sat_now;
        end else if (sat_now) begin
            sat_seen <= 1'b1;
        end
    end
`else
    // Add this cycle's edge; the counter wraps modulo 2^COUNT_WIDTH.
    assign count_next = edge_cnt + COUNT_WIDTH'(rise);
`endif

    // Gate counter and edge counter; at window end the closing count (including this cycle's edge) is latched whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            code     <= '0;
        end else if (window_end) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            code     <= count_next;
        end else begin
            gate_cnt <= gate_cnt + GATE_WIDTH'(1);
            edge_cnt <= count_next;
        end
    end

    // Sticky new-code flag: setting at window end wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt <= 1'b0;
        end else if (window_end) begin
            interrupt <= 1'b1;
        end else if (interrupt_clear) begin
            interrupt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_count_gate.sv
// Self-checking bench for freq_count_gate: a full-width instance driven by a
// table of gate/period vectors plus directed corner sequences, and a 4-bit
// instance for counter wrap/saturation.
module tb_freq_count_gate;

    localparam int CW  = 28;
    localparam int GW  = 32;
    localparam int NCW = 4;

    typedef struct {
        int gate;
        int period;
        int exp_code;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           int_clear;
    logic [GW-1:0]  gate_a;
    logic [GW-1:0]  gate_b;
    int             period_a;
    int             period_b;
    int             phase_a = 0;
    int             phase_b = 0;
    logic           manual_a;
    logic           gen_a;
    logic           gen_b;
    logic           iclk_a;
    logic           iclk_b;
    logic [CW-1:0]  code_a;
    logic [NCW-1:0] code_b;
    logic           interrupt_a;
    logic           interrupt_b;
`ifdef FREQ_COUNT_SATURATE_EN
    logic           overflow_a;
    logic           overflow_b;
    localparam int  NARROW_EXP = 15;
`else
    localparam int  NARROW_EXP = 4;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc;
    bit   ok;
    vec_t vecs[7];

    assign iclk_a = (period_a == 0) ? manual_a : gen_a;
    assign iclk_b = gen_b;

    always #5 clk = ~clk;

    freq_count_gate #(.COUNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(2)) dut_a (
        .clk                (clk),
        .reset              (reset),
        .iclk               (iclk_a),
        .clk_frequency_div4 (gate_a),
        .code               (code_a),
`ifdef FREQ_COUNT_SATURATE_EN
        .overflow           (overflow_a),
`endif
        .interrupt          (interrupt_a),
        .interrupt_clear    (int_clear)
    );

    freq_count_gate #(.COUNT_WIDTH(NCW), .GATE_WIDTH(GW), .SYNC_STAGES(2)) dut_b (
        .clk                (clk),
        .reset              (reset),
        .iclk               (iclk_b),
        .clk_frequency_div4 (gate_b),
        .code               (code_b),
`ifdef FREQ_COUNT_SATURATE_EN
        .overflow           (overflow_b),
`endif
        .interrupt          (interrupt_b),
        .interrupt_clear    (int_clear)
    );

    // Periodic square waves on the measured inputs, 50 % duty, updated on the falling clk edge.
    initial begin
        gen_a = 1'b0;
        gen_b = 1'b0;
        forever begin
            @(negedge clk);
            if (period_a > 0) begin
                gen_a   = (phase_a < period_a / 2);
                phase_a = (phase_a + 1 >= period_a) ? 0 : phase_a + 1;
            end
            if (period_b > 0) begin
                gen_b   = (phase_b < period_b / 2);
                phase_b = (phase_b + 1 >= period_b) ? 0 : phase_b + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        gate_a   = GW'(v.gate);
        period_a = v.period;
    endtask

    // Wait for the next negedge at which the selected interrupt is high; counts negedges waited.
    task automatic waitWindowEnd(input bit use_b, input int budget, output int cycles, output bit done);
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
            done = use_b ? interrupt_b : interrupt_a;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL window_timeout: got no interrupt within %0d cycles, want one", budget);
        end
    endtask

    initial begin
        vecs[0] = '{gate: 100, period: 10, exp_code: 10};
        vecs[1] = '{gate: 60,  period: 6,  exp_code: 10};
        vecs[2] = '{gate: 1,   period: 0,  exp_code: 0};
        vecs[3] = '{gate: 0,   period: 0,  exp_code: 0};
        vecs[4] = '{gate: 2,   period: 2,  exp_code: 1};
        vecs[5] = '{gate: 50,  period: 2,  exp_code: 25};
        vecs[6] = '{gate: 24,  period: 8,  exp_code: 3};

        reset     = 1'b1;
        int_clear = 1'b0;
        gate_a    = GW'(100);
        period_a  = 0;
        manual_a  = 1'b0;
        gate_b    = GW'(40);
        period_b  = 2;

        // Reset state and the first window after deassertion.
        repeat (3) @(negedge clk);
        checkOutput("reset_code_a", code_a, 0);
        checkOutput("reset_int_a", interrupt_a, 0);
        checkOutput("reset_code_b", code_b, 0);
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 10) begin
                checkOutput("early_code", code_a, 0);
                checkOutput("early_int", interrupt_a, 0);
            end
            if (k == 99) checkOutput("int_before_end", interrupt_a, 0);
            if (k == 100) begin
                checkOutput("int_first_end", interrupt_a, 1);
                checkOutput("code_first_end", code_a, 0);
            end
        end

        // Sticky interrupt, one-cycle clear pulse, then clear held across a window end.
        repeat (30) @(negedge clk);
        checkOutput("int_sticky", interrupt_a, 1);
        int_clear = 1'b1;
        @(negedge clk);
        checkOutput("int_clear_pulse", interrupt_a, 0);
        int_clear = 1'b0;
        @(negedge clk);
        int_clear = 1'b1;
        waitWindowEnd(1'b0, 200, cyc, ok);
        if (ok) checkOutput("int_set_over_clear_cycles", cyc, 68);
        @(negedge clk);
        checkOutput("int_clear_after_end", interrupt_a, 0);

        // Edge reaching rise on the window-end cycle belongs to the closing window.
        waitWindowEnd(1'b0, 200, cyc, ok);
        repeat (97) @(negedge clk);
        manual_a = 1'b1;
        waitWindowEnd(1'b0, 200, cyc, ok);
        if (ok) checkOutput("edge_at_end_cycles", cyc, 3);
        checkOutput("edge_at_end_code", code_a, 1);
        waitWindowEnd(1'b0, 200, cyc, ok);
        checkOutput("edge_next_window", code_a, 0);
        manual_a = 1'b0;

        // Gate shrinks 100 -> 20 while gate_cnt is 50: window ends on the next clock.
        waitWindowEnd(1'b0, 200, cyc, ok);
        repeat (50) @(negedge clk);
        gate_a   = GW'(20);
        period_a = 4;
        @(negedge clk);
        checkOutput("gate_shrink_end", interrupt_a, 1);
        waitWindowEnd(1'b0, 60, cyc, ok);
        waitWindowEnd(1'b0, 60, cyc, ok);
        if (ok) checkOutput("gate_shrink_len", cyc, 20);
        checkOutput("gate_shrink_code", code_a, 5);

        // Table-driven windows: settle two windows, then check length and count of the third.
        for (int i = 0; i < 7; i++) begin
            int len;
            len = (vecs[i].gate < 1) ? 1 : vecs[i].gate;
            applyStimulus(vecs[i]);
            waitWindowEnd(1'b0, 2 * len + 20, cyc, ok);
            waitWindowEnd(1'b0, 2 * len + 20, cyc, ok);
            waitWindowEnd(1'b0, 2 * len + 20, cyc, ok);
            if (ok) checkOutput($sformatf("row%0d_len", i), cyc, len);
            checkOutput($sformatf("row%0d_code", i), code_a, vecs[i].exp_code);
        end

        // Narrow counter: 20 edges per 40-cycle window, then 10 edges per window.
        waitWindowEnd(1'b1, 100, cyc, ok);
        waitWindowEnd(1'b1, 100, cyc, ok);
        waitWindowEnd(1'b1, 100, cyc, ok);
        if (ok) checkOutput("narrow_len", cyc, 40);
        checkOutput("narrow_code_20_edges", code_b, NARROW_EXP);
`ifdef FREQ_COUNT_SATURATE_EN
        checkOutput("narrow_overflow_set", overflow_b, 1);
`endif
        period_b = 4;
        waitWindowEnd(1'b1, 100, cyc, ok);
        waitWindowEnd(1'b1, 100, cyc, ok);
        waitWindowEnd(1'b1, 100, cyc, ok);
        checkOutput("narrow_code_10_edges", code_b, 10);
`ifdef FREQ_COUNT_SATURATE_EN
        checkOutput("narrow_overflow_clear", overflow_b, 0);
`endif

        // Asynchronous reset mid-window clears outputs without a clock edge.
        int_clear = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("pre_reset_int_a", interrupt_a, 1);
        checkOutput("pre_reset_int_b", interrupt_b, 1);
        checkOutput("pre_reset_code_a", code_a, 3);
        checkOutput("pre_reset_code_b", code_b, 10);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_code_a", code_a, 0);
        checkOutput("async_reset_int_a", interrupt_a, 0);
        checkOutput("async_reset_code_b", code_b, 0);
        checkOutput("async_reset_int_b", interrupt_b, 0);
`ifdef FREQ_COUNT_SATURATE_EN
        checkOutput("async_reset_overflow_a", overflow_a, 0);
        checkOutput("async_reset_overflow_b", overflow_b, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", checks - failures, checks);
        $finish;
    end

endmodule
